regfile_2r1w_sb: RTL and testbench

- Parametrised successor to the single-port processor register file.
- Two combinational read ports and one write-back port, with same-cycle write-to-read bypass.
- Per-register scoreboard: busy bits are set at issue and cleared at write-back.
- Issue-stage hazard (stall) detection; sits between decode/issue and write-back in the pipeline.

---
 rtl/regfile_2r1w_sb.sv | 92 +++++++++
 tb/tb_regfile_2r1w_sb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sb.sv
// Two-read / one-write register file with write-back bypass,
// per-register busy scoreboard and issue-stage hazard detection.
module regfile_2r1w_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt
);

    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     cnt_q;

    logic legal_a, legal_b, legal_i, legal_w;
    logic hit_a, hit_b, hit_i;
    logic dest_busy, set_v, clr_v, inc, dec;

    assign legal_a = legal(rd_addr_a);
    assign legal_b = legal(rd_addr_b);
    assign legal_i = legal(issue_addr);
    assign legal_w = legal(wr_addr);

    assign hit_a = wr_en && (wr_addr == rd_addr_a);
    assign hit_b = wr_en && (wr_addr == rd_addr_b);
    assign hit_i = wr_en && (wr_addr == issue_addr);

    // A source or destination being written back this cycle is no longer busy
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (legal_a) rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
        if (legal_b) rd_data_b = hit_b ? wr_data : regs[rd_addr_b];
    end

    assign busy_a    = legal_a && busy[rd_addr_a] && !hit_a;
    assign busy_b    = legal_b && busy[rd_addr_b] && !hit_b;
    assign dest_busy = legal_i && busy[issue_addr] && !hit_i;

    assign stall = issue_en &&
                   ((rd_en_a && busy_a) || (rd_en_b && busy_b) || dest_busy);

    assign set_v = issue_en && !stall && legal_i;
    assign clr_v = wr_en && legal_w;
    assign inc   = set_v && !busy[issue_addr];
    assign dec   = clr_v && busy[wr_addr] &&
                   !(set_v && (issue_addr == wr_addr));

    // Set after clear so a re-issue to the written index keeps it pending
    always_comb begin
        busy_nxt = busy;
        if (clr_v) busy_nxt[wr_addr] = 1'b0;
        if (set_v) busy_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            if (clr_v) regs[wr_addr] <= wr_data;
            busy  <= busy_nxt;
            cnt_q <= cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_regfile_2r1w_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en_a, rd_en_b, wr_en, issue_en;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        busy_a, busy_b, stall;
    logic [5:0]  pending_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] mreg  [32];
    bit          mbusy [32];

    regfile_2r1w_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_a(busy_a), .busy_b(busy_b), .stall(stall),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit leg(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!leg(a)) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        return leg(a) && mbusy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic bit exp_stall();
        return issue_en && ((rd_en_a && exp_busy(rd_addr_a)) ||
                            (rd_en_b && exp_busy(rd_addr_b)) ||
                            exp_busy(issue_addr));
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    // Advance the model by the rules for the current inputs, then clock.
    task automatic tick();
        bit acc;
        acc = issue_en && !exp_stall();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i] = 32'd0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (wr_en && leg(wr_addr)) begin
                mreg[wr_addr] = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (acc && leg(issue_addr)) mbusy[issue_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; rd_en_a = 0; rd_en_b = 0; wr_en = 0; issue_en = 0;
        rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; issue_addr = 0;
        wr_data = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; rd_addr_a = 5'd1; rd_addr_b = 5'd31;
        rd_en_a = 1; rd_en_b = 1;
        #1;
        tests++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            fails++;
            $display("FAIL reset_data: a=%h b=%h want 0", rd_data_a, rd_data_b);
        end
        tests++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: ba=%b bb=%b st=%b want 0",
                     busy_a, busy_b, stall);
        end
        tests++;
        if (pending_cnt !== 6'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d want 0", pending_cnt);
        end
    endtask

    task automatic test_write_bypass();
        idle();
        wr_en = 1; wr_addr = 5'd1; wr_data = 32'd2; rd_addr_a = 5'd1;
        #1;
        tests++;
        if (rd_data_a !== 32'd2) begin
            fails++;
            $display("FAIL bypass: got %h want 2", rd_data_a);
        end
        tick();
        wr_en = 0;
        #1;
        tests++;
        if (rd_data_a !== 32'd2) begin
            fails++;
            $display("FAIL stored: got %h want 2", rd_data_a);
        end
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0;
        #1;
        tests++;
        if (rd_data_a !== 32'd0) begin
            fails++;
            $display("FAIL r0_bypass: got %h want 0", rd_data_a);
        end
        tick();
        wr_en = 0;
        #1;
        tests++;
        if (rd_data_a !== 32'd0) begin
            fails++;
            $display("FAIL r0_stored: got %h want 0", rd_data_a);
        end
    endtask

    task automatic test_raw();
        idle();
        issue_en = 1; issue_addr = 5'd5;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL raw_issue: stall=%b want 0", stall);
        end
        tick();
        tests++;
        if (pending_cnt !== 6'd1) begin
            fails++;
            $display("FAIL raw_cnt1: got %0d want 1", pending_cnt);
        end
        rd_en_a = 1; rd_addr_a = 5'd5; issue_addr = 5'd6;
        #1;
        tests++;
        if (busy_a !== 1'b1 || stall !== 1'b1) begin
            fails++;
            $display("FAIL raw_stall: ba=%b st=%b want 1 1", busy_a, stall);
        end
        tick();
        issue_addr = 5'd0;
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'h1234;
        #1;
        tests++;
        if (busy_a !== 1'b0 || stall !== 1'b0 || rd_data_a !== 32'h1234) begin
            fails++;
            $display("FAIL raw_wb: ba=%b st=%b d=%h want 0 0 1234",
                     busy_a, stall, rd_data_a);
        end
        tick();
        tests++;
        if (pending_cnt !== 6'd0) begin
            fails++;
            $display("FAIL raw_cnt0: got %0d want 0", pending_cnt);
        end
    endtask

    task automatic test_waw();
        idle();
        issue_en = 1; issue_addr = 5'd7;
        tick();
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL waw_stall: got %b want 1", stall);
        end
        tick();
        tests++;
        if (pending_cnt !== 6'd1) begin
            fails++;
            $display("FAIL waw_cnt: got %0d want 1", pending_cnt);
        end
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'h77;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL waw_wb_stall: got %b want 0", stall);
        end
        tick();
        idle();
        rd_en_a = 1; rd_addr_a = 5'd7;
        #1;
        tests++;
        if (busy_a !== 1'b1 || pending_cnt !== 6'd1) begin
            fails++;
            $display("FAIL waw_setwins: ba=%b cnt=%0d want 1 1",
                     busy_a, pending_cnt);
        end
        wr_en = 1; wr_addr = 5'd7;
        tick();
        idle();
    endtask

    task automatic test_fill_drain();
        idle();
        for (int i = 1; i < 32; i++) begin
            issue_en = 1; issue_addr = 5'(i);
            tick();
            tests++;
            if (int'(pending_cnt) != i || int'(pending_cnt) != exp_cnt()) begin
                fails++;
                $display("FAIL fill_cnt: got %0d want %0d", pending_cnt, i);
            end
        end
        issue_addr = 5'd0;
        tick();
        tests++;
        if (pending_cnt !== 6'd31) begin
            fails++;
            $display("FAIL fill_r0: got %0d want 31", pending_cnt);
        end
        issue_en = 0;
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = $urandom;
            tick();
            tests++;
            if (int'(pending_cnt) != 31 - i ||
                int'(pending_cnt) != exp_cnt()) begin
                fails++;
                $display("FAIL drain_cnt: got %0d want %0d",
                         pending_cnt, 31 - i);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        issue_en = 1; issue_addr = 5'd3;
        tick();
        rst_n = 0; issue_addr = 5'd9;
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'hDEAD_BEEF;
        tick();
        idle();
        rd_addr_a = 5'd4; rd_addr_b = 5'd3; rd_en_b = 1;
        #1;
        tests++;
        if (rd_data_a !== 32'd0 || busy_b !== 1'b0 || pending_cnt !== 6'd0) begin
            fails++;
            $display("FAIL reset_mid: d=%h bb=%b cnt=%0d want 0 0 0",
                     rd_data_a, busy_b, pending_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 79) != 0);
            rd_en_a    = $urandom_range(0, 1);
            rd_en_b    = $urandom_range(0, 1);
            rd_addr_a  = 5'($urandom_range(0, 7));
            rd_addr_b  = 5'($urandom_range(0, 31));
            issue_en   = $urandom_range(0, 1);
            issue_addr = 5'($urandom_range(0, 7));
            wr_en      = $urandom_range(0, 1);
            wr_addr    = 5'($urandom_range(0, 7));
            wr_data    = $urandom;
            #1;
            tests++;
            if (rd_data_a !== exp_rd(rd_addr_a) ||
                rd_data_b !== exp_rd(rd_addr_b)) begin
                fails++;
                $display("FAIL rand_data: a=%h/%h b=%h/%h", rd_data_a,
                         exp_rd(rd_addr_a), rd_data_b, exp_rd(rd_addr_b));
            end
            tests++;
            if (busy_a !== exp_busy(rd_addr_a) ||
                busy_b !== exp_busy(rd_addr_b) || stall !== exp_stall()) begin
                fails++;
                $display("FAIL rand_hazard: ba=%b/%b bb=%b/%b st=%b/%b",
                         busy_a, exp_busy(rd_addr_a), busy_b,
                         exp_busy(rd_addr_b), stall, exp_stall());
            end
            tick();
            tests++;
            if (int'(pending_cnt) != exp_cnt()) begin
                fails++;
                $display("FAIL rand_cnt: got %0d want %0d",
                         pending_cnt, exp_cnt());
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 32'd0;
            mbusy[i] = 1'b0;
        end
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_bypass();
        test_raw();
        test_waw();
        test_fill_drain();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
